// File: rtl/serial_twos_complementer_p.sv
// Bit-serial pass / one's / two's complement / absolute-value unit.
// The word is shifted LSB-first through one inverter, half-adder and carry flop, and re-enters at the MSB.
module serial_twos_complementer_p #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ovf,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_ONES = 2'b01;
  localparam logic [1:0] M_NEG  = 2'b10;
  localparam logic [1:0] M_ABS  = 2'b11;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] sreg_q,     sreg_d;
  logic             carry_q,    carry_d;
  logic             inv_q,      inv_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] result_q,   result_d;
  logic             ovf_q,      ovf_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             cout_q,     cout_d;

  logic bit_b;
  logic bit_s;
  logic carry_nx;
  logic accept;
  logic eff_neg;

  always_comb begin
    bit_b    = sreg_q[0] ^ inv_q;
    bit_s    = bit_b ^ carry_q;
    carry_nx = bit_b & carry_q;
    accept   = start && (state_q != ST_RUN);
    // ABS resolves to NEG only for negative operands, otherwise it is a plain pass
    eff_neg  = (mode == M_NEG) || ((mode == M_ABS) && data_in[WIDTH-1]);

    state_d    = state_q;
    sreg_d     = sreg_q;
    carry_d    = carry_q;
    inv_d      = inv_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    cout_d     = cout_q;

    case (state_q)
      ST_RUN: begin
        sreg_d  = {bit_s, sreg_q[WIDTH-1:1]};
        carry_d = carry_nx;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d  = ST_DONE;
          result_d = {bit_s, sreg_q[WIDTH-1:1]};
          ovf_d    = ovf_pend_q;
          cout_d   = carry_nx;
        end
      end
      default: begin
        if (accept) begin
          state_d    = ST_RUN;
          sreg_d     = data_in;
          cnt_d      = '0;
          carry_d    = eff_neg;
          inv_d      = eff_neg || (mode == M_ONES);
          ovf_pend_d = eff_neg && (data_in == MOST_NEG);
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      carry_q    <= 1'b0;
      inv_q      <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      carry_q    <= carry_d;
      inv_q      <= inv_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      cout_q     <= cout_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign ser_out   = busy & bit_s;
  assign ser_valid = busy;
  assign ovf       = ovf_q;
  assign cout      = cout_q;

endmodule
